// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the FIR MAC sequencer
package fir_pkg;

  localparam int DATA_W   = 16;  // sample and coefficient width
  localparam int TAPS_DEF = 10;  // default number of MAC taps
  localparam int DIV_DEF  = 40;  // default clocks per sample period (12 MHz / 300 kHz)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACC  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_sample_div.sv
// rtl/fir_sample_div.sv - sample-rate divider producing a one-cycle strobe
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   strobe out registered strobe, high exactly while the count is DIV-1
module fir_sample_div
  import fir_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic strobe
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] count;

  // The strobe is registered one count early so that it is high in the
  // same cycle the counter holds DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      strobe <= 1'b0;
    end else begin
      if (count == CNT_W'(DIV - 1)) begin
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
      strobe <= (count == CNT_W'(DIV - 2));
    end
  end

endmodule

// File: rtl/fir_mac_ctrl.sv
// rtl/fir_mac_ctrl.sv - FIR MAC tap sequencer with double-buffered coefficients
// Optional feature macro: FIR_COEFF_READBACK_EN (adds iRdAddr / oRdData)
// Ports:
//   iClk_12M        in   system clock
//   iRsn            in   asynchronous active-low reset
//   iSample         in   signed input sample
//   iSampleValid    in   iSample holds a fresh sample
//   iCoeffWe        in   coefficient write strobe
//   iCoeffAddr      in   coefficient tap index (1..TAPS)
//   iCoeffData      in   signed coefficient write data
//   oEnSample_300k  out  one-cycle sample strobe
//   oFirIn          out  sample held for the current sequence
//   oCoeff          out  coefficient of the active tap
//   oEnMul          out  active tap index, 0 when no tap is active
//   oEnAdd          out  tap add enable
//   oEnAcc          out  final accumulate enable
//   oBusy           out  sequence in progress
//   oUnderrun       out  pulse when no fresh sample was present at the strobe
//   iRdAddr         in   readback address (FIR_COEFF_READBACK_EN only)
//   oRdData         out  write-bank readback data (FIR_COEFF_READBACK_EN only)
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int DIV  = DIV_DEF
) (
  input  logic                     iClk_12M,
  input  logic                     iRsn,
  input  logic signed [DATA_W-1:0] iSample,
  input  logic                     iSampleValid,
  input  logic                     iCoeffWe,
  input  logic        [3:0]        iCoeffAddr,
  input  logic signed [DATA_W-1:0] iCoeffData,
  output logic                     oEnSample_300k,
  output logic signed [DATA_W-1:0] oFirIn,
  output logic signed [DATA_W-1:0] oCoeff,
  output logic        [3:0]        oEnMul,
  output logic                     oEnAdd,
  output logic                     oEnAcc,
  output logic                     oBusy,
  output logic                     oUnderrun
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic        [3:0]        iRdAddr,
  output logic signed [DATA_W-1:0] oRdData
`endif
);

  localparam logic [3:0] TAPS_A = 4'(TAPS);

  logic signed [DATA_W-1:0] wbank  [1:TAPS];
  logic signed [DATA_W-1:0] shadow [1:TAPS];
  state_t                   state;
  logic                     strobe;
  logic                     wr_ok;
  logic        [3:0]        next_tap;

  fir_sample_div #(
    .DIV(DIV)
  ) u_div (
    .clk   (iClk_12M),
    .rst_n (iRsn),
    .strobe(strobe)
  );

  assign oEnSample_300k = strobe;
  assign wr_ok          = iCoeffWe && (iCoeffAddr != 4'd0) && (iCoeffAddr <= TAPS_A);
  assign next_tap       = oEnMul + 4'd1;

  // Write bank: illegal addresses are simply dropped.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      wbank <= '{default: '0};
    end else if (wr_ok) begin
      wbank[iCoeffAddr] <= iCoeffData;
    end
  end

  // Sequencer. The shadow copy on the strobe edge reads the write bank's
  // pre-edge contents, so a write in the strobe cycle only reaches the next
  // sequence. oEnMul doubles as the tap counter.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state     <= IDLE;
      shadow    <= '{default: '0};
      oFirIn    <= '0;
      oCoeff    <= '0;
      oEnMul    <= '0;
      oEnAdd    <= 1'b0;
      oEnAcc    <= 1'b0;
      oBusy     <= 1'b0;
      oUnderrun <= 1'b0;
    end else begin
      oUnderrun <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            shadow <= wbank;
            if (iSampleValid) begin
              oFirIn <= iSample;
            end else begin
              oUnderrun <= 1'b1;
            end
            oCoeff <= wbank[1];
            oEnMul <= 4'd1;
            oEnAdd <= 1'b1;
            oBusy  <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (oEnMul == TAPS_A) begin
            oEnMul <= 4'd0;
            oEnAdd <= 1'b0;
            oEnAcc <= 1'b1;
            state  <= ACC;
          end else begin
            oEnMul <= next_tap;
            oCoeff <= shadow[next_tap];
          end
        end
        ACC: begin
          oEnAcc <= 1'b0;
          oBusy  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  logic rd_ok;
  assign rd_ok = (iRdAddr != 4'd0) && (iRdAddr <= TAPS_A);

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oRdData <= '0;
    end else begin
      oRdData <= rd_ok ? wbank[iRdAddr] : '0;
    end
  end
`endif

endmodule

// File: doc/fir_mac_ctrl.md
FIR_MAC_CTRL -- requirements
Module: fir_mac_ctrl

Interface
REQ-001 Parameter TAPS, default 10, number of MAC taps sequenced per sample; legal range 2..15.
REQ-002 Parameter DIV, default 40, clock cycles per sample period (12 MHz / 300 kHz); SHALL be at least TAPS+3.
REQ-003 iClk_12M  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 iRsn  in  1  reset, asynchronous, active-low.
REQ-005 iSample  in  16 signed  FIR input sample.
REQ-006 iSampleValid  in  1  iSample holds a fresh sample.
REQ-007 iCoeffWe  in  1  coefficient write strobe.
REQ-008 iCoeffAddr  in  4  coefficient tap index, 1..TAPS.
REQ-009 iCoeffData  in  16 signed  coefficient write data.
REQ-010 oEnSample_300k  out  1  one-cycle sample strobe.
REQ-011 oFirIn  out  16 signed  sample held for the current sequence.
REQ-012 oCoeff  out  16 signed  coefficient of the active tap.
REQ-013 oEnMul  out  4  active tap index; 0 when no tap is active.
REQ-014 oEnAdd  out  1  tap add enable.
REQ-015 oEnAcc  out  1  final accumulate enable.
REQ-016 oBusy  out  1  sequence in progress.
REQ-017 oUnderrun  out  1  one-cycle pulse when no fresh sample is present at the strobe.

Function
REQ-018 Divider counter SHALL count 0..DIV-1 and wrap to 0; oEnSample_300k SHALL be 1 exactly in the cycle where count==DIV-1.
REQ-019 Coefficient write bank SHALL be TAPS x 16; a write with iCoeffWe=1 and iCoeffAddr in 1..TAPS SHALL update that entry on the same clock edge.
REQ-020 Writes with address 0 or address >TAPS SHALL be ignored and SHALL NOT affect any other entry.
REQ-021 On the strobe edge (T), the shadow bank SHALL copy the complete write bank; a write in cycle T SHALL land in the write bank only, not in the shadow bank.
REQ-022 On edge T, oFirIn SHALL capture iSample if iSampleValid=1; otherwise oFirIn SHALL hold its previous value and oUnderrun SHALL pulse in cycle T+1.
REQ-023 FSM states: IDLE, RUN, ACC.
REQ-024 FSM transitions: IDLE->RUN on the strobe; RUN->ACC after tap TAPS; ACC->IDLE after one cycle.
REQ-025 In RUN cycle k (k=1..TAPS, at cycles T+1..T+TAPS), oEnMul SHALL equal k, oCoeff SHALL equal shadow[k], and oEnAdd SHALL be 1.
REQ-026 In ACC (cycle T+TAPS+1), oEnAcc SHALL be 1, oEnMul SHALL be 0, and oEnAdd SHALL be 0.
REQ-027 In IDLE, oEnMul, oEnAdd and oEnAcc SHALL be 0, and oCoeff SHALL hold its last value.
REQ-028 oBusy SHALL be 1 in RUN and ACC and 0 in IDLE.
REQ-029 A strobe outside IDLE is unreachable by REQ-002; if it occurs anyway, it SHALL be ignored (no restart, no capture).
REQ-030 All outputs SHALL be registered (no combinational path from any input to any output).

Reset
REQ-031 While iRsn=0, all outputs, the divider, the FSM (IDLE), and both coefficient banks SHALL be 0, asynchronously.
REQ-032 Reset mid-sequence SHALL abort the sequence immediately; after release, the divider SHALL restart from 0, giving the first strobe DIV cycles later.

Configuration
REQ-033 With FIR_COEFF_READBACK_EN defined, ports iRdAddr (in, 4) and oRdData (out, 16 signed) SHALL exist; oRdData SHALL equal write-bank[iRdAddr] one cycle later, and 0 for an illegal address.
REQ-034 Without FIR_COEFF_READBACK_EN, those ports and their logic SHALL be absent, with all other behaviour identical.

Structure
REQ-035 A shared package fir_pkg SHALL hold the FSM state typedef, the coefficient/sample width constant (16), and the defaults for TAPS and DIV.
REQ-036 The divider SHALL be a sub-module fir_sample_div (outputs the strobe); the banks and FSM SHALL stay in fir_mac_ctrl.

Verification
REQ-037 Reset release, then 80 clocks -> strobes at cycles 39 and 79 after release; no other oEnSample_300k pulse.
REQ-038 Write coeff k=100*k for k=1..10, sample 0x0123 valid -> in cycles T+1..T+10, oEnMul=1..10 and oCoeff=100..1000; oEnAcc=1 at T+11; oFirIn=0x0123.
REQ-039 Write addr 5=0x7FFF in cycle T, then addr 0 and addr 12 -> current sequence tap 5 uses old value; next sequence tap 5=0x7FFF; all other taps unchanged.
REQ-040 iSampleValid=0 at the strobe -> oUnderrun pulses once at T+1; oFirIn keeps the previous sample.
REQ-041 Assert iRsn=0 at T+4 -> all outputs 0 immediately; after release, the next strobe is exactly 40 clocks later.
REQ-042 With FIR_COEFF_READBACK_EN, set iRdAddr=3 after writing 0x8001 -> oRdData=0x8001 one cycle later; iRdAddr=0 -> oRdData=0.
